// File: rtl/add128_carry_resolve_if.sv
// Handshake bundle for the 128-bit adder carry-resolution stage: partial-sum input
// channel and resolved-sum output channel.
interface add128_carry_resolve_if;
    logic         in_valid;
    logic         in_ready;
    logic [159:0] in_psum;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] sum;
    logic         cout;

    modport master (
        output in_valid,
        output in_psum,
        output cin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  cout
    );

    modport slave (
        input  in_valid,
        input  in_psum,
        input  cin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output cout
    );
endinterface

// File: rtl/add128_carry_resolve.sv
// Ripples inter-slice carries through 32 captured 5-bit slice partial sums,
// SLICES_PER_CYCLE slices per cycle, and presents the 128-bit sum plus carry-out.
module add128_carry_resolve #(
    // Legal values: 1, 2, 4, 8, 16, 32.
    parameter int unsigned SLICES_PER_CYCLE = 8
) (
    input logic                         clk,
    input logic                         rst,
    add128_carry_resolve_if.slave       bus
);

    localparam logic [4:0] Step    = 5'(SLICES_PER_CYCLE);
    localparam logic [4:0] LastIdx = 5'(32 - SLICES_PER_CYCLE);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e         state_q;
    logic [159:0]   psum_q;
    logic           carry_q;
    logic [4:0]     idx_q;
    logic [127:0]   sum_q;
    logic           cout_q;

    logic [127:0]   sum_d;
    logic           carry_d;
    logic [4:0]     slice;
    logic [4:0]     s;

    // Carry chains combinationally through this cycle's slices; s wraps in 5 bits.
    always_comb begin
        sum_d   = sum_q;
        carry_d = carry_q;
        slice   = '0;
        s       = '0;
        for (int unsigned j = 0; j < SLICES_PER_CYCLE; j++) begin
            slice = idx_q + 5'(j);
            s     = psum_q[{3'b000, slice} * 8'd5 +: 5] + {4'b0000, carry_d};
            sum_d[{slice, 2'b00} +: 4] = s[3:0];
            carry_d = s[4];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            psum_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        psum_q  <= bus.in_psum;
                        carry_q <= bus.cin;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    sum_q   <= sum_d;
                    carry_q <= carry_d;
                    idx_q   <= idx_q + Step;
                    if (idx_q == LastIdx) begin
                        cout_q  <= carry_d;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_add128_carry_resolve.sv
// Directed checks on the default and single-slice configurations, then a random
// a+b+cin regression running concurrently on every legal slices-per-cycle setting.
module tb_add128_carry_resolve;

    logic clk = 1'b0;
    logic rst;
    int   assert_cnt = 0;
    int   fail_cnt   = 0;
    bit   rand_go    = 1'b0;

    always #5 clk = ~clk;

    add128_carry_resolve_if d8_bus ();
    add128_carry_resolve_if d1_bus ();

    add128_carry_resolve #(.SLICES_PER_CYCLE(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (d8_bus)
    );

    add128_carry_resolve #(.SLICES_PER_CYCLE(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (d1_bus)
    );

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        assert_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [159:0] fill(input logic [4:0] v);
        logic [159:0] r;
        for (int i = 0; i < 32; i++) r[5*i +: 5] = v;
        return r;
    endfunction

    task automatic op8(input string tag, input logic [159:0] ps, input logic ci,
                       input logic [127:0] es, input logic ec);
        int lat;
        d8_bus.in_psum  = ps;
        d8_bus.cin      = ci;
        d8_bus.in_valid = 1'b1;
        tick();
        d8_bus.in_valid = 1'b0;
        lat = 0;
        while (!d8_bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 160'(lat), 160'(4));
        check({tag, "_sum"}, {32'b0, d8_bus.sum}, {32'b0, es});
        check({tag, "_cout"}, {159'b0, d8_bus.cout}, {159'b0, ec});
    endtask

    task automatic release8(input string tag);
        d8_bus.out_ready = 1'b1;
        tick();
        d8_bus.out_ready = 1'b0;
        check({tag, "_rel_ready"}, {159'b0, d8_bus.in_ready}, 160'd1);
        check({tag, "_rel_valid"}, {159'b0, d8_bus.out_valid}, 160'd0);
    endtask

    for (genvar g = 0; g < 6; g++) begin : g_rand
        localparam int unsigned P = 32'd1 << g;
        add128_carry_resolve_if rbus ();
        add128_carry_resolve #(.SLICES_PER_CYCLE(P)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (rbus)
        );
        bit           done = 1'b0;
        logic [127:0] a;
        logic [127:0] b;
        logic         c;
        logic [128:0] exp;
        logic [159:0] ps;
        int           lat;

        initial begin
            rbus.in_valid  = 1'b0;
            rbus.out_ready = 1'b0;
            rbus.cin       = 1'b0;
            rbus.in_psum   = '0;
            wait (rand_go);
            tick();
            for (int k = 0; k < 1000; k++) begin
                a   = {$urandom(), $urandom(), $urandom(), $urandom()};
                b   = {$urandom(), $urandom(), $urandom(), $urandom()};
                c   = 1'($urandom_range(0, 1));
                for (int i = 0; i < 32; i++) begin
                    ps[5*i +: 5] = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]};
                end
                exp = {1'b0, a} + {1'b0, b} + {128'b0, c};
                rbus.in_psum  = ps;
                rbus.cin      = c;
                rbus.in_valid = 1'b1;
                tick();
                rbus.in_valid = 1'b0;
                lat = 0;
                while (!rbus.out_valid && lat < 100) begin
                    tick();
                    lat++;
                end
                check($sformatf("rand%0d_lat", P), 160'(lat), 160'(32 / P));
                check($sformatf("rand%0d_sum", P), {31'b0, rbus.cout, rbus.sum}, {31'b0, exp});
                repeat ($urandom_range(0, 2)) tick();
                rbus.out_ready = 1'b1;
                tick();
                rbus.out_ready = 1'b0;
            end
            done = 1'b1;
        end
    end

    initial begin
        int lat;
        int cyc;
        logic [127:0] bp_sum;

        rst              = 1'b1;
        d8_bus.in_valid  = 1'b0;
        d8_bus.out_ready = 1'b0;
        d8_bus.cin       = 1'b0;
        d8_bus.in_psum   = '0;
        d1_bus.in_valid  = 1'b0;
        d1_bus.out_ready = 1'b0;
        d1_bus.cin       = 1'b0;
        d1_bus.in_psum   = '0;
        repeat (2) tick();
        check("rst_in_ready", {159'b0, d8_bus.in_ready}, 160'd1);
        check("rst_out_valid", {159'b0, d8_bus.out_valid}, 160'd0);
        check("rst_sum", {32'b0, d8_bus.sum}, 160'd0);
        check("rst_cout", {159'b0, d8_bus.cout}, 160'd0);
        rst = 1'b0;
        tick();

        op8("ones", fill(5'h1e), 1'b0, {{31{4'hf}}, 4'he}, 1'b1);
        release8("ones");
        op8("ripple8", fill(5'h0f), 1'b1, 128'd0, 1'b1);
        release8("ripple8");
        op8("zero", fill(5'h00), 1'b0, 128'd0, 1'b0);
        release8("zero");
        op8("cin_only", fill(5'h00), 1'b1, 128'd1, 1'b0);
        release8("cin_only");

        // Full ripple one slice per cycle.
        d1_bus.in_psum  = fill(5'h0f);
        d1_bus.cin      = 1'b1;
        d1_bus.in_valid = 1'b1;
        tick();
        d1_bus.in_valid = 1'b0;
        lat = 0;
        while (!d1_bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check("ripple1_lat", 160'(lat), 160'(32));
        check("ripple1_sum", {32'b0, d1_bus.sum}, 160'd0);
        check("ripple1_cout", {159'b0, d1_bus.cout}, 160'd1);
        d1_bus.out_ready = 1'b1;
        tick();
        d1_bus.out_ready = 1'b0;

        // Backpressure with ignored in_valid pulses.
        bp_sum = {{31{4'h5}}, 4'h6};
        op8("bp", fill(5'h05), 1'b1, bp_sum, 1'b0);
        d8_bus.in_psum = fill(5'h00);
        for (int k = 0; k < 6; k++) begin
            d8_bus.in_valid = (k % 2 == 0);
            tick();
            check("bp_valid", {159'b0, d8_bus.out_valid}, 160'd1);
            check("bp_in_ready", {159'b0, d8_bus.in_ready}, 160'd0);
            check("bp_sum", {32'b0, d8_bus.sum}, {32'b0, bp_sum});
            check("bp_cout", {159'b0, d8_bus.cout}, 160'd0);
        end
        d8_bus.in_valid = 1'b0;
        release8("bp");
        repeat (2) tick();
        check("bp_not_queued", {159'b0, d8_bus.out_valid}, 160'd0);
        check("bp_idle_ready", {159'b0, d8_bus.in_ready}, 160'd1);

        // Reset in the second RUN cycle.
        d8_bus.in_psum  = fill(5'h1e);
        d8_bus.cin      = 1'b0;
        d8_bus.in_valid = 1'b1;
        tick();
        d8_bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready", {159'b0, d8_bus.in_ready}, 160'd1);
        check("midrst_out_valid", {159'b0, d8_bus.out_valid}, 160'd0);
        check("midrst_sum", {32'b0, d8_bus.sum}, 160'd0);
        check("midrst_cout", {159'b0, d8_bus.cout}, 160'd0);
        op8("after_rst", fill(5'h05), 1'b0, {32{4'h5}}, 1'b0);
        release8("after_rst");

        rand_go = 1'b1;
        cyc = 0;
        while (!(g_rand[0].done && g_rand[1].done && g_rand[2].done && g_rand[3].done &&
                 g_rand[4].done && g_rand[5].done) && cyc < 60000) begin
            tick();
            cyc++;
        end
        check("rand_complete", 160'(cyc < 60000), 160'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
